// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants and coordinate type
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - enabled wrap counter 0..MAX with wrap flag and next-value output
module vga_axis_counter
    import vga_pkg::coord_t;
#(
    parameter int unsigned MAX = 799
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   en,
    output coord_t cnt,
    output coord_t cnt_next,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(MAX);

    coord_t cnt_q;
    coord_t cnt_d;

    always_comb begin
        wrap  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + coord_t'(1);
        end
    end

    // Reset parks on the last value so the first enabled cycle lands on 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: counters, registered syncs, blank and frame pulses
module vga_timing_gen
    import vga_pkg::coord_t;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_VIS      = coord_t'(H_VISIBLE);
    localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t V_VIS      = coord_t'(V_VISIBLE);
    localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t hc, vc, hc_next, vc_next;
    logic   h_wrap, v_wrap;

    vga_axis_counter #(.MAX(H_TOTAL - 1)) u_h_counter (
        .clk      (vga_clk),
        .resetn   (reset_n),
        .en       (1'b1),
        .cnt      (hc),
        .cnt_next (hc_next),
        .wrap     (h_wrap)
    );

    vga_axis_counter #(.MAX(V_TOTAL - 1)) u_v_counter (
        .clk      (vga_clk),
        .resetn   (reset_n),
        .en       (h_wrap),
        .cnt      (vc),
        .cnt_next (vc_next),
        .wrap     (v_wrap)
    );

    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_start_q, vblank_start_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       first_q, first_d;

    // Decode from the next counter value so the flopped outputs line up
    // with DrawX/DrawY in the cycle they become visible.
    always_comb begin
        hs_d           = !((hc_next >= HS_START) && (hc_next < HS_END));
        vs_d           = !((vc_next >= VS_START) && (vc_next < VS_END));
        blank_d        = (hc_next < H_VIS) && (vc_next < V_VIS);
        frame_start_d  = (hc_next == '0) && (vc_next == '0);
        vblank_start_d = (hc_next == '0) && (vc_next == V_VIS);
        frame_cnt_d    = frame_cnt_q;
        first_d        = first_q;
        // The wrap out of reset enters frame 0, so it is not counted.
        if (v_wrap) begin
            if (first_q) begin
                first_d = 1'b0;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            blank_q        <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_cnt_q    <= 8'd0;
            first_q        <= 1'b1;
        end else begin
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            blank_q        <= blank_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_cnt_q    <= frame_cnt_d;
            first_q        <= first_d;
        end
    end

    assign hs           = hs_q;
    assign vs           = vs_q;
    assign blank        = blank_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_cnt    = frame_cnt_q;
    assign DrawX        = hc;
    assign DrawY        = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (default and shrunken timing)
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int SHV = 4, SHF = 1, SHS = 2, SHB = 1;
    localparam int SVV = 3, SVF = 1, SVS = 2, SVB = 1;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;
    localparam int SFRAME = SHT * SVT;

    typedef struct {
        int x;
        int y;
        int fc;
        bit first;
    } st_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic       vbs;
        logic [7:0] fc;
    } exp_t;

    logic vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    logic       reset_n, s_reset_n;
    logic       hs, vs, blank, frame_start, vblank_start;
    logic [9:0] DrawX, DrawY;
    logic [7:0] frame_cnt;
    logic       s_hs, s_vs, s_blank, s_frame_start, s_vblank_start;
    logic [9:0] s_DrawX, s_DrawY;
    logic [7:0] s_frame_cnt;

    vga_timing_gen dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .hs(hs), .vs(vs), .blank(blank),
        .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .vblank_start(vblank_start), .frame_cnt(frame_cnt)
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_small (
        .vga_clk(vga_clk), .reset_n(s_reset_n), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .DrawX(s_DrawX), .DrawY(s_DrawY), .frame_start(s_frame_start),
        .vblank_start(s_vblank_start), .frame_cnt(s_frame_cnt)
    );

    int   vectors = 0;
    int   miscompares = 0;
    st_t  m_st, s_st;
    exp_t m_q[$];
    exp_t s_q[$];
    exp_t m_e, s_e;
    exp_t m_obs, s_obs;
    logic prev_hs, prev_vs;
    bit   prev_valid = 1'b0;

    assign m_obs = {DrawX, DrawY, hs, vs, blank, frame_start, vblank_start, frame_cnt};
    assign s_obs = {s_DrawX, s_DrawY, s_hs, s_vs, s_blank, s_frame_start, s_vblank_start, s_frame_cnt};

    function automatic st_t rst_state(int ht, int vt);
        st_t n;
        n.x = ht - 1;
        n.y = vt - 1;
        n.fc = 0;
        n.first = 1'b1;
        return n;
    endfunction

    function automatic st_t adv(st_t s, int ht, int vt);
        st_t n = s;
        if (s.x == ht - 1) begin
            n.x = 0;
            if (s.y == vt - 1) begin
                n.y = 0;
                if (!s.first) n.fc = (s.fc + 1) % 256;
                n.first = 1'b0;
            end else begin
                n.y = s.y + 1;
            end
        end else begin
            n.x = s.x + 1;
        end
        return n;
    endfunction

    function automatic exp_t decode(st_t s, int hv, int hf, int hsw, int vv, int vf, int vsw);
        exp_t e;
        e.x     = 10'(s.x);
        e.y     = 10'(s.y);
        e.hs    = !(s.x >= hv + hf && s.x < hv + hf + hsw);
        e.vs    = !(s.y >= vv + vf && s.y < vv + vf + vsw);
        e.blank = (s.x < hv) && (s.y < vv);
        e.fs    = (s.x == 0) && (s.y == 0);
        e.vbs   = (s.x == 0) && (s.y == vv);
        e.fc    = 8'(s.fc);
        return e;
    endfunction

    task automatic tick(input bit rn_m, input bit rn_s);
        reset_n   = rn_m;
        s_reset_n = rn_s;
        m_st = rn_m ? adv(m_st, 800, 525) : rst_state(800, 525);
        s_st = rn_s ? adv(s_st, SHT, SVT) : rst_state(SHT, SVT);
        m_q.push_back(decode(m_st, 640, 16, 96, 480, 10, 2));
        s_q.push_back(decode(s_st, SHV, SHF, SHS, SVV, SVF, SVS));
        @(posedge vga_clk);
        #1;
    endtask

    always @(negedge vga_clk) begin
        if (m_q.size() > 0) begin
            m_e = m_q.pop_front();
            vectors++;
            if (m_obs !== m_e) begin
                miscompares++;
                $display("FAIL sb_main t=%0t act=%h exp=%h", $time, m_obs, m_e);
            end
            vectors++;
            if (int'(DrawX) >= 800 || int'(DrawY) >= 525 ||
                (blank === 1'b1 && (int'(DrawX) >= 640 || int'(DrawY) >= 480))) begin
                miscompares++;
                $display("FAIL range_check act x=%0d y=%0d blank=%b req x<800 y<525 blank->visible",
                         DrawX, DrawY, blank);
            end
            if (prev_valid && blank === 1'b1) begin
                vectors++;
                if (hs !== prev_hs || vs !== prev_vs) begin
                    miscompares++;
                    $display("FAIL sync_stable_in_visible act hs=%b vs=%b req hs=%b vs=%b",
                             hs, vs, prev_hs, prev_vs);
                end
            end
            prev_hs = hs;
            prev_vs = vs;
            prev_valid = 1'b1;
        end
        if (s_q.size() > 0) begin
            s_e = s_q.pop_front();
            vectors++;
            if (s_obs !== s_e) begin
                miscompares++;
                $display("FAIL sb_small t=%0t act=%h exp=%h", $time, s_obs, s_e);
            end
        end
    end

    task automatic test_reset();
        exp_t rv;
        rv = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            vectors++;
            if (m_obs !== rv) begin
                miscompares++;
                $display("FAIL reset_values act=%h req=%h", m_obs, rv);
            end
        end
        tick(1'b1, 1'b1);
        vectors++;
        if (DrawX !== 10'd0 || DrawY !== 10'd0 || blank !== 1'b1 || frame_start !== 1'b1 || frame_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL first_pixel act x=%0d y=%0d blank=%b fs=%b fc=%0d req 0 0 1 1 0",
                     DrawX, DrawY, blank, frame_start, frame_cnt);
        end
        tick(1'b1, 1'b1);
        vectors++;
        if (DrawX !== 10'd1 || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL second_pixel act x=%0d fs=%b req x=1 fs=0", DrawX, frame_start);
        end
    endtask

    task automatic test_line();
        int hs_low = 0, hs_first = -1, blank_low = 0, blank_hi = 0;
        int px = -1, py = -1;
        bit done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            px = int'(DrawX);
            py = int'(DrawY);
            tick(1'b1, 1'b1);
            if (hs === 1'b0) begin
                if (hs_first < 0) hs_first = int'(DrawX);
                hs_low++;
            end
            if (DrawY === 10'd0) begin
                if (blank === 1'b0) blank_low++;
                else blank_hi++;
            end
            if (DrawY === 10'd1) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL line_timeout act y=%0d req y=1 within 1000 cycles", DrawY);
        end
        vectors++;
        if (hs_low != 96) begin
            miscompares++;
            $display("FAIL hs_width act=%0d req=96", hs_low);
        end
        vectors++;
        if (hs_first != 656) begin
            miscompares++;
            $display("FAIL hs_start act=%0d req=656", hs_first);
        end
        vectors++;
        if (blank_low != 160 || blank_hi != 638) begin
            miscompares++;
            $display("FAIL blank_line0 act low=%0d high=%0d req low=160 high=638", blank_low, blank_hi);
        end
        vectors++;
        if (px != 799 || py != 0 || DrawX !== 10'd0 || DrawY !== 10'd1) begin
            miscompares++;
            $display("FAIL line_wrap act (%0d,%0d)->(%0d,%0d) req (799,0)->(0,1)", px, py, DrawX, DrawY);
        end
    endtask

    task automatic test_frames();
        bit found = 1'b0;
        int fc0, vs_low = 0, vs_bad = 0, vbs = 0, vbs_bad = 0;
        int fs_cnt = 0, last_fs = 0, gap_bad = 0, fc_bad = 0;
        for (int i = 0; i < SFRAME + 2 && !found; i++) begin
            tick(1'b1, 1'b1);
            if (s_frame_start === 1'b1) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL frame_start_timeout act none req pulse within %0d cycles", SFRAME + 2);
        end
        fc0 = s_st.fc;
        for (int i = 1; i <= 2 * SFRAME; i++) begin
            tick(1'b1, 1'b1);
            if (s_vs === 1'b0) begin
                vs_low++;
                if (int'(s_DrawY) < SVV + SVF || int'(s_DrawY) >= SVV + SVF + SVS) vs_bad++;
            end
            if (s_vblank_start === 1'b1) begin
                vbs++;
                if (int'(s_DrawX) != 0 || int'(s_DrawY) != SVV) vbs_bad++;
            end
            if (s_frame_start === 1'b1) begin
                fs_cnt++;
                if (i - last_fs != SFRAME) gap_bad++;
                last_fs = i;
                if (s_frame_cnt !== 8'(fc0 + fs_cnt)) fc_bad++;
            end
        end
        vectors++;
        if (vs_low != 2 * SVS * SHT || vs_bad != 0) begin
            miscompares++;
            $display("FAIL vs_window act low=%0d bad=%0d req low=%0d bad=0", vs_low, vs_bad, 2 * SVS * SHT);
        end
        vectors++;
        if (vbs != 2 || vbs_bad != 0) begin
            miscompares++;
            $display("FAIL vblank_start act count=%0d bad=%0d req count=2 bad=0", vbs, vbs_bad);
        end
        vectors++;
        if (fs_cnt != 2 || gap_bad != 0) begin
            miscompares++;
            $display("FAIL frame_period act count=%0d badgaps=%0d req count=2 gap=%0d", fs_cnt, gap_bad, SFRAME);
        end
        vectors++;
        if (fc_bad != 0) begin
            miscompares++;
            $display("FAIL frame_cnt_step act bad=%0d req 0", fc_bad);
        end
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        exp_t rv;
        rv = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        for (int i = 0; i < 1600 && !found; i++) begin
            tick(1'b1, 1'b1);
            if (DrawX === 10'd300) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_reset_seek act x=%0d req x=300", DrawX);
        end
        tick(1'b0, 1'b0);
        vectors++;
        if (m_obs !== rv) begin
            miscompares++;
            $display("FAIL mid_reset_values act=%h req=%h", m_obs, rv);
        end
        vectors++;
        if (s_frame_cnt !== 8'd0 || int'(s_DrawX) != SHT - 1 || int'(s_DrawY) != SVT - 1) begin
            miscompares++;
            $display("FAIL mid_reset_small act fc=%0d x=%0d y=%0d req 0 %0d %0d",
                     s_frame_cnt, s_DrawX, s_DrawY, SHT - 1, SVT - 1);
        end
        tick(1'b1, 1'b1);
        vectors++;
        if (DrawX !== 10'd0 || DrawY !== 10'd0 || blank !== 1'b1 || frame_start !== 1'b1 || frame_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL restart_first act x=%0d y=%0d blank=%b fs=%b fc=%0d req 0 0 1 1 0",
                     DrawX, DrawY, blank, frame_start, frame_cnt);
        end
        tick(1'b1, 1'b1);
        vectors++;
        if (DrawX !== 10'd1 || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_second act x=%0d fs=%b req x=1 fs=0", DrawX, frame_start);
        end
        found = 1'b0;
        for (int i = 0; i < SFRAME + 2 && !found; i++) begin
            tick(1'b1, 1'b1);
            if (s_frame_start === 1'b1) found = 1'b1;
        end
        vectors++;
        if (!found || s_frame_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL second_frame_cnt act found=%b fc=%0d req found=1 fc=1", found, s_frame_cnt);
        end
    endtask

    task automatic test_frame_cnt_wrap();
        logic [7:0] prev_fc;
        bit wrapped = 1'b0;
        prev_fc = s_frame_cnt;
        for (int i = 0; i < 260 * SFRAME && !wrapped; i++) begin
            tick(1'b1, 1'b1);
            if (s_frame_cnt !== prev_fc) begin
                vectors++;
                if (s_frame_start !== 1'b1) begin
                    miscompares++;
                    $display("FAIL fc_change_off_frame_start act fs=%b fc=%0d req fs=1", s_frame_start, s_frame_cnt);
                end
                if (prev_fc === 8'd255) begin
                    wrapped = 1'b1;
                    vectors++;
                    if (s_frame_cnt !== 8'd0) begin
                        miscompares++;
                        $display("FAIL fc_wrap_value act=%0d req=0", s_frame_cnt);
                    end
                end
                prev_fc = s_frame_cnt;
            end
        end
        vectors++;
        if (!wrapped) begin
            miscompares++;
            $display("FAIL fc_wrap_timeout act fc=%0d req wrap 255->0", s_frame_cnt);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        s_reset_n = 1'b0;
        m_st = rst_state(800, 525);
        s_st = rst_state(SHT, SVT);
        test_reset();
        test_line();
        test_frames();
        test_mid_reset();
        test_frame_cnt_wrap();
        @(negedge vga_clk);
        @(negedge vga_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have the parameters below (name, default, meaning); the defaults SHALL match those in vga_pkg.
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels; H_TOTAL = 800.
- V_VISIBLE, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines; V_TOTAL = 525.
REQ-002 The block SHALL have the ports below (name, direction, width, meaning).
- vga_clk, in, 1, pixel clock (25 MHz), the only clock.
- reset_n, in, 1, reset that is synchronous to vga_clk and active-low.
- hs, out, 1, horizontal sync, active-low.
- vs, out, 1, vertical sync, active-low.
- blank, out, 1, 1 = visible pixel (downstream drawers gate their colour on blank high).
- DrawX, out, 10, current pixel column.
- DrawY, out, 10, current pixel row.
- frame_start, out, 1, one-cycle pulse at pixel (0,0).
- vblank_start, out, 1, one-cycle pulse at pixel (0,V_VISIBLE).
- frame_cnt, out, 8, free-running frame number used for animation and blinking.

Function
REQ-003 The horizontal counter hc SHALL count 0..H_TOTAL-1 and advance by 1 on every vga_clk cycle; it SHALL wrap from H_TOTAL-1 to 0.
REQ-004 The vertical counter vc SHALL advance only in cycles where hc wraps; it SHALL count 0..V_TOTAL-1 and wrap from V_TOTAL-1 to 0.
REQ-005 DrawX SHALL equal hc and DrawY SHALL equal vc, with zero additional latency.
REQ-006 hs SHALL be 0 exactly when H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC, which is hc 656..751 with the defaults.
REQ-007 vs SHALL be 0 exactly when V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC, which is vc 490..491 with the defaults.
REQ-008 blank SHALL be 1 exactly when hc < H_VISIBLE and vc < V_VISIBLE.
REQ-009 hs, vs, blank, frame_start and vblank_start SHALL be driven from flops, decoded from the next counter value, so that each one describes the same pixel as DrawX/DrawY in the same cycle; there SHALL be no combinational path from the counters to these outputs.
REQ-010 frame_start SHALL be 1 only in cycles where (DrawX,DrawY) = (0,0).
REQ-011 vblank_start SHALL be 1 only in cycles where (DrawX,DrawY) = (0,480).
REQ-012 frame_cnt SHALL increment by 1 on each wrap of the counters from (799,524) to (0,0), wrapping from 255 to 0, except on the first (0,0) after reset is released.
REQ-013 Line and frame periods SHALL be exactly 800 and 420000 cycles respectively, with no dropped or repeated pixels.

Reset
REQ-014 While reset_n = 0 at a rising edge of vga_clk, the block SHALL load hc = 799, vc = 524, hs = 1, vs = 1, blank = 0, frame_start = 0, vblank_start = 0 and frame_cnt = 0.
REQ-015 In the first cycle after reset_n returns to 1, the outputs SHALL be DrawX = 0, DrawY = 0, blank = 1, frame_start = 1 and frame_cnt = 0.
REQ-016 Asserting reset mid-frame SHALL take effect at the next clock edge, regardless of counter position, and SHALL abort the current frame.

Structure
REQ-017 The timing constants (visible, porch and sync widths, totals) and the 10-bit coordinate typedef SHALL live in a shared package, vga_pkg, which drawer blocks also import.
REQ-018 One sub-module, vga_axis_counter (a parameterised wrap counter with a wrap flag output), SHALL be instantiated twice: once for horizontal and once for vertical, with the horizontal wrap flag chained into the vertical enable.

Verification
REQ-019 Release reset, run 2 cycles -> first cycle (0,0), blank = 1, frame_start = 1, frame_cnt = 0; second cycle DrawX = 1, frame_start = 0.
REQ-020 Run one line -> hs = 0 for exactly 96 cycles, starting at DrawX = 656; blank = 0 at DrawX = 640..799; DrawY goes 0 -> 1 as DrawX goes 799 -> 0.
REQ-021 Run two full frames -> vs = 0 only for DrawY 490..491 (1600 cycles); vblank_start pulses once per frame at (0,480); frame_start pulses are 420000 cycles apart; frame_cnt reads 1 in the second frame.
REQ-022 Run 256 frames (a force/skip mode is acceptable) -> frame_cnt wraps from 255 to 0 coincident with frame_start.
REQ-023 Assert reset_n = 0 for 1 cycle at (300,200) -> outputs take the reset values of REQ-014 at the next edge, and the sequence then restarts as in REQ-019.
REQ-024 Continuous assertion checks -> DrawX < 800, DrawY < 525, blank implies DrawX < 640 and DrawY < 480, and hs/vs never change while blank = 1.
